mem_arbiter: RTL and testbench

Sequences the single-ported RAM between the pipeline's instruction-fetch and data-memory requesters. Sits between the datapath's cache interface and the RAM model. Each grant is latched, and the RAM transaction runs to completion. The winning requester gets a one-cycle hit pulse with the load data. Data requests normally have priority, but when both sides are waiting, grants alternate so fetch is never starved.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter_watchdog.sv | 36 +++
 rtl/mem_arbiter.sv | 115 +++++++++++
 tb/tb_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the instruction/data RAM arbiter.
//   arb_state_t   - arbiter FSM states (IDLE, IACC, DACC)
//   arb_latch_t   - access payload captured at grant (address, store data, write flag)
//   ARB_TIMEOUT_W - default watchdog counter width for ARB_TIMEOUT_CYCLES
package mem_arbiter_pkg;

    localparam int unsigned WORD_W             = 32;
    localparam int unsigned ARB_TIMEOUT_CYCLES = 64;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } arb_state_t;

    typedef struct packed {
        word_t addr;
        word_t store;
        logic  wen;
    } arb_latch_t;

    // Counter width able to hold the value cycles.
    function automatic int unsigned arb_timeout_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int unsigned ARB_TIMEOUT_W = arb_timeout_w(ARB_TIMEOUT_CYCLES);

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side requests/hits and RAM-side strobes of the arbiter.
//   slave  - arbiter view (takes requests and RAM responses, drives hits and strobes)
//   master - environment view (cache requesters plus RAM model)
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic  iREN;
    word_t iaddr;
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  ihit;
    word_t iload;
    logic  dhit;
    word_t dload;
    logic  ramREN;
    logic  ramWEN;
    word_t ramaddr;
    word_t ramstore;
    word_t ramload;
    logic  ramready;
    logic  arb_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
    );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// arb_watchdog: access-cycle counter for the arbiter (built only with ARB_TIMEOUT_EN).
//   CLK, RST  - clock, async active-high reset
//   clr       - grant: restart the count
//   run       - an access is in progress
//   expire_c  - this is the TIMEOUT_CYCLES-th access cycle
`ifdef ARB_TIMEOUT_EN
module arb_watchdog
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES,
    parameter int unsigned CNT_W          = arb_timeout_w(TIMEOUT_CYCLES)
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic run,
    output logic expire_c
);

    logic [CNT_W-1:0] cnt_q;

    // Count completed access cycles; saturates at the expiry value.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (run && !expire_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign expire_c = run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between instruction fetch and data memory.
//   CLK, RST - clock, async active-high reset
//   bus      - mem_arbiter_if.slave: iREN/iaddr, dREN/dWEN/daddr/dstore requests,
//              ihit/iload, dhit/dload completions, ramREN/ramWEN/ramaddr/ramstore
//              strobes, ramload/ramready from the RAM, sticky arb_err
// Optional feature: define ARB_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES
// RAM cycles and raise arb_err; otherwise arb_err is 0 and accesses wait forever.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);

    arb_state_t state_q, state_d;
    logic       last_d_q, last_d_d;
    arb_latch_t lat_q, lat_d;
    logic       d_req_c;
    logic       active_c;
    logic       expire_c;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    assign d_req_c  = bus.dREN | bus.dWEN;
    assign active_c = (state_q != IDLE);

    // State and grant latches.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            lat_q    <= lat_d;
        end
    end

    // Grant selection; data wins unless the previous grant was also data and fetch waits.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        lat_d    = lat_q;
        unique case (state_q)
            IDLE: begin
                if (d_req_c && !(bus.iREN && last_d_q)) begin
                    state_d  = DACC;
                    last_d_d = 1'b1;
                    lat_d    = '{addr: bus.daddr, store: bus.dstore, wen: bus.dWEN};
                end else if (bus.iREN) begin
                    state_d  = IACC;
                    last_d_d = 1'b0;
                    lat_d    = '{addr: bus.iaddr, store: '0, wen: 1'b0};
                end
            end
            IACC, DACC: begin
                if (bus.ramready || expire_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completion counts only if the owner still asks for the same access.
    assign bus.ihit = (state_q == IACC) && bus.ramready && bus.iREN
                      && (bus.iaddr == lat_q.addr);
    assign bus.dhit = (state_q == DACC) && bus.ramready && d_req_c
                      && (bus.daddr == lat_q.addr) && (bus.dWEN == lat_q.wen);

    assign bus.iload    = bus.ihit ? bus.ramload : '0;
    assign bus.dload    = (bus.dhit && !lat_q.wen) ? bus.ramload : '0;
    assign bus.ramREN   = active_c && !lat_q.wen;
    assign bus.ramWEN   = active_c && lat_q.wen;
    assign bus.ramaddr  = active_c ? lat_q.addr  : '0;
    assign bus.ramstore = active_c ? lat_q.store : '0;

`ifdef ARB_TIMEOUT_EN
    logic err_q;
    logic grant_c;

    assign grant_c = (state_q == IDLE) && (state_d != IDLE);

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_arb_watchdog (
        .CLK      (CLK),
        .RST      (RST),
        .clr      (grant_c),
        .run      (active_c),
        .expire_c (expire_c)
    );

    // Sticky: a real completion in the expiry cycle is not a timeout.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            err_q <= 1'b0;
        end else if (expire_c && !bus.ramready) begin
            err_q <= 1'b1;
        end
    end

    assign bus.arb_err = err_q;
`else
    assign expire_c    = 1'b0;
    assign bus.arb_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed protocol checks plus randomized traffic for mem_arbiter.
// Completions are predicted into per-requester queues when a request is raised and
// popped by an independent monitor whenever ihit/dhit appears.
module tb_mem_arbiter;

    logic CLK;
    logic RST;
    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] ram_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    // RAM model configuration: 0 fixed latency, 1 random 1..4, 2 never ready
    int ram_mode = 0;
    int fix_lat  = 1;
    int cur_lat  = 1;
    int ram_cnt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1234};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // RAM: ramready in the L-th strobe cycle, garbage on ramload otherwise.
    always begin
        @(posedge CLK);
        #1;
        if (bus.ramREN || bus.ramWEN) begin
            if (ram_cnt == 0) cur_lat = (ram_mode == 1) ? int'($urandom_range(1, 4)) : fix_lat;
            ram_cnt++;
            if (ram_mode != 2 && ram_cnt == cur_lat) begin
                bus.ramready = 1'b1;
                if (bus.ramWEN) begin
                    ram_mem[bus.ramaddr] = bus.ramstore;
                    bus.ramload = $urandom;
                end else begin
                    bus.ramload = ram_rd(bus.ramaddr);
                end
            end else begin
                bus.ramready = 1'b0;
                bus.ramload  = $urandom;
            end
        end else begin
            ram_cnt      = 0;
            bus.ramready = 1'b0;
            bus.ramload  = $urandom;
        end
    end

    // Monitor: every hit must match the oldest prediction for that requester.
    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.ihit === 1'b1) begin
                if (iq.size() == 0) check("ihit_unexpected", 32'd1, 32'd0);
                else check("iload", bus.iload, iq.pop_front());
            end
            if (bus.dhit === 1'b1) begin
                if (dq.size() == 0) check("dhit_unexpected", 32'd1, 32'd0);
                else check("dload", bus.dload, dq.pop_front());
            end
            if (bus.ramREN === 1'b1 && bus.ramWEN === 1'b1) check("strobe_excl", 32'd1, 32'd0);
        end
    end

    task automatic wait_hit(input bit is_d, input string nm);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (is_d ? bus.dhit : bus.ihit) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check(nm, 32'd0, 32'd1);
        cyc();
    endtask

    task automatic i_access(input logic [31:0] a);
        bus.iREN  = 1'b1;
        bus.iaddr = a;
        iq.push_back(ref_rd(a));
        wait_hit(1'b0, "ihit_timeout");
        bus.iREN = 1'b0;
    endtask

    task automatic d_access(input logic [31:0] a, input bit wr, input logic [31:0] st, input bit both);
        bus.daddr  = a;
        bus.dstore = st;
        if (wr) begin
            bus.dWEN = 1'b1;
            bus.dREN = both;
            ref_mem[a] = st;
            dq.push_back(32'h0);
        end else begin
            bus.dWEN = 1'b0;
            bus.dREN = 1'b1;
            dq.push_back(ref_rd(a));
        end
        wait_hit(1'b1, "dhit_timeout");
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [2:0] exp_code [0:8];
        logic [2:0] code;

        RST          = 1'b1;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.daddr    = '0;
        bus.dstore   = '0;
        bus.ramready = 1'b1;
        bus.ramload  = 32'hFFFF_FFFF;
        ram_mem[32'h40] = 32'h8C22_0004;
        ref_mem[32'h40] = 32'h8C22_0004;
        #1;
        check("rst_ctrl", 32'({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.arb_err}), 32'd0);
        check("rst_iload", bus.iload, 32'd0);
        check("rst_dload", bus.dload, 32'd0);
        check("rst_ramaddr", bus.ramaddr, 32'd0);
        check("rst_ramstore", bus.ramstore, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        cyc();

        // Reset in the middle of a data access drops the strobes at once.
        ram_mode  = 2;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h200;
        @(negedge CLK);
        @(negedge CLK);
        check("rstmid_pre_ramREN", 32'(bus.ramREN), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("rstmid_strobes", 32'({bus.ramREN, bus.ramWEN}), 32'd0);
        check("rstmid_ramaddr", bus.ramaddr, 32'd0);
        bus.dREN = 1'b0;
        cyc();
        cyc();
        RST = 1'b0;
        ram_mode = 0;
        fix_lat  = 1;
        cyc();

        // Contention after reset: D first, then alternating, one bubble between accesses.
        exp_code = '{3'b000, 3'b011, 3'b000, 3'b101, 3'b000, 3'b011, 3'b000, 3'b101, 3'b000};
        bus.dREN  = 1'b1;
        bus.daddr = 32'h108;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h0C;
        repeat (2) dq.push_back(ref_rd(32'h108));
        repeat (2) iq.push_back(ref_rd(32'h0C));
        for (int c = 0; c <= 8; c++) begin
            @(negedge CLK);
            code = {bus.ihit, bus.dhit, bus.ramREN | bus.ramWEN};
            check($sformatf("contention_c%0d", c), 32'(code), 32'(exp_code[c]));
            if (c == 7) begin
                cyc();
                bus.iREN = 1'b0;
                bus.dREN = 1'b0;
            end
        end
        cyc();

        // Single fetch with RAM latency 2.
        fix_lat   = 2;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h40;
        iq.push_back(32'h8C22_0004);
        @(negedge CLK);
        check("fetch_c0_ramREN", 32'(bus.ramREN), 32'd0);
        @(negedge CLK);
        check("fetch_c1_ramREN", 32'(bus.ramREN), 32'd1);
        check("fetch_c1_ramaddr", bus.ramaddr, 32'h40);
        check("fetch_c1_ihit", 32'(bus.ihit), 32'd0);
        @(negedge CLK);
        check("fetch_c2_ihit", 32'(bus.ihit), 32'd1);
        check("fetch_c2_iload", bus.iload, 32'h8C22_0004);
        cyc();
        bus.iREN = 1'b0;
        @(negedge CLK);
        check("fetch_c3_ihit", 32'(bus.ihit), 32'd0);
        check("fetch_c3_ramREN", 32'(bus.ramREN), 32'd0);
        cyc();

        // Write wins over read when both are raised.
        bus.dREN   = 1'b1;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h100;
        bus.dstore = 32'hDEAD_BEEF;
        ref_mem[32'h100] = 32'hDEAD_BEEF;
        dq.push_back(32'h0);
        @(negedge CLK);
        @(negedge CLK);
        check("wr_strobes", 32'({bus.ramWEN, bus.ramREN}), 32'b10);
        check("wr_ramstore", bus.ramstore, 32'hDEAD_BEEF);
        check("wr_ramaddr", bus.ramaddr, 32'h100);
        @(negedge CLK);
        check("wr_dhit", 32'(bus.dhit), 32'd1);
        check("wr_dload", bus.dload, 32'd0);
        cyc();
        bus.dREN = 1'b0;
        bus.dWEN = 1'b0;
        cyc();

        // Fetch withdrawn mid-access: no ihit, then pending data read is granted.
        fix_lat   = 3;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h80;
        @(negedge CLK);
        @(negedge CLK);
        check("wd_c1_ramaddr", bus.ramaddr, 32'h80);
        cyc();
        bus.iREN  = 1'b0;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h104;
        dq.push_back(ref_rd(32'h104));
        @(negedge CLK);
        @(negedge CLK);
        check("wd_c3_ihit", 32'(bus.ihit), 32'd0);
        @(negedge CLK);
        check("wd_c4_bubble", 32'(bus.ramREN | bus.ramWEN), 32'd0);
        @(negedge CLK);
        check("wd_c5_ramREN", 32'(bus.ramREN), 32'd1);
        check("wd_c5_ramaddr", bus.ramaddr, 32'h104);
        wait_hit(1'b1, "wd_dhit_timeout");
        bus.dREN = 1'b0;
        cyc();

`ifdef ARB_TIMEOUT_EN
        // RAM never answers: abort after four access cycles.
        ram_mode  = 2;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'hC0;
        repeat (5) @(negedge CLK);
        check("wdog_c4_ramREN", 32'(bus.ramREN), 32'd1);
        cyc();
        bus.iREN = 1'b0;
        @(negedge CLK);
        check("wdog_c5_ramREN", 32'(bus.ramREN), 32'd0);
        check("wdog_c5_arb_err", 32'(bus.arb_err), 32'd1);
        cyc();
`endif

        // Random traffic from both requesters against the random-latency RAM.
        ram_mode = 1;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    i_access(32'(4 * $urandom_range(0, 63)));
                    repeat ($urandom_range(0, 3)) cyc();
                end
            end
            begin
                for (int n = 0; n < 40; n++) begin
                    d_access(32'h1000 + 32'(4 * $urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                             $urandom, 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 3)) cyc();
                end
            end
        join
        repeat (4) cyc();

`ifdef ARB_TIMEOUT_EN
        check("end_arb_err_sticky", 32'(bus.arb_err), 32'd1);
`else
        check("end_arb_err", 32'(bus.arb_err), 32'd0);
`endif
        check("end_iq_empty", 32'(iq.size()), 32'd0);
        check("end_dq_empty", 32'(dq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
